// File: rtl/alu_entry_ctrl_pkg.sv
// Shared constants for the ALU operand-entry front end: FSM encodings, debounce default
// and the ALU opcode values the entered mode field is decoded against.
package alu_entry_ctrl_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_OPCODE = 2'd0,
        S_A      = 2'd1,
        S_B      = 2'd2,
        S_RUN    = 2'd3
    } entry_state_e;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;

endpackage

// File: rtl/alu_entry_ctrl_btn_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stable-count debouncer and a one-cycle
// pulse on each accepted press (debounced 0->1).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        // Accept the new level on the edge where the count would reach DEBOUNCE_CYCLES.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_entry_ctrl.sv
// Operand-entry controller: steps through opcode, A, B (+carry) on debounced next/back
// presses and holds the latched fields for the ALU while in the run state.
module alu_entry_ctrl
    import alu_entry_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       sw_cin,
    input  logic       btn_next,
    input  logic       btn_back,
    output logic [3:0] mode_d,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       c_in,
    output logic [1:0] entry_state,
    output logic       operands_valid
);

    logic next_pulse, back_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_next),
        .press   (next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_back),
        .press   (back_pulse)
    );

    entry_state_e state_q, state_d;
    logic [3:0]   opcode_q, opcode_d;
    logic [3:0]   a_q, a_d;
    logic [3:0]   b_q, b_d;
    logic         cin_q, cin_d;
    logic         valid_q, valid_d;
    logic [1:0]   cin_sync_q, cin_sync_d;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        cin_sync_d = {cin_sync_q[0], sw_cin};
        // Next wins over a coincident back.
        if (next_pulse) begin
            unique case (state_q)
                S_OPCODE: begin
                    opcode_d = sw;
                    state_d  = S_A;
                end
                S_A: begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw;
                    cin_d   = cin_sync_q[1];
                    state_d = S_RUN;
                end
                S_RUN: state_d = S_OPCODE;
            endcase
        end else if (back_pulse) begin
            case (state_q)
                S_A:     state_d = S_OPCODE;
                S_B:     state_d = S_A;
                S_RUN:   state_d = S_B;
                default: state_d = state_q;
            endcase
        end
        valid_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_OPCODE;
            opcode_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            valid_q    <= 1'b0;
            cin_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            valid_q    <= valid_d;
            cin_sync_q <= cin_sync_d;
        end
    end

    assign mode_d         = opcode_q;
    assign a              = a_q;
    assign b              = b_q;
    assign c_in           = cin_q;
    assign entry_state    = state_q;
    assign operands_valid = valid_q;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Scoreboard bench for alu_entry_ctrl: a reference model pushes the expected output
// word for each accepted press; a monitor pops and compares on every output change.
module tb_alu_entry_ctrl;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       sw_cin;
    logic       btn_next;
    logic       btn_back;
    logic [3:0] mode_d, a, b;
    logic       c_in;
    logic [1:0] entry_state;
    logic       operands_valid;

    alu_entry_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw             (sw),
        .sw_cin         (sw_cin),
        .btn_next       (btn_next),
        .btn_back       (btn_back),
        .mode_d         (mode_d),
        .a              (a),
        .b              (b),
        .c_in           (c_in),
        .entry_state    (entry_state),
        .operands_valid (operands_valid)
    );

    always #5 clk = ~clk;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic [15:0]  exp_q[$];
    logic [15:0]  prev_obs = '0;
    bit           mon_en   = 0;

    logic [1:0] m_st;
    logic [3:0] m_mode, m_a, m_b;
    logic       m_cin;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output word: {state, valid, c_in, mode, a, b}.
    function automatic logic [15:0] pk(input logic [1:0] st, input logic c,
                                       input logic [3:0] m, input logic [3:0] aa,
                                       input logic [3:0] bb);
        return {st, (st == 2'd3), c, m, aa, bb};
    endfunction

    function automatic logic [15:0] obs();
        return {entry_state, operands_valid, c_in, mode_d, a, b};
    endfunction

    always @(negedge clk) begin
        logic [15:0] cur;
        cur = obs();
        if (mon_en && cur !== prev_obs) begin
            if (exp_q.size() == 0) check_eq("unexpected_change", cur, prev_obs);
            else check_eq("scoreboard", cur, exp_q.pop_front());
        end
        prev_obs = cur;
    end

    task automatic push_model();
        exp_q.push_back(pk(m_st, m_cin, m_mode, m_a, m_b));
    endtask

    task automatic model_next();
        case (m_st)
            2'd0: begin m_mode = sw; m_st = 2'd1; end
            2'd1: begin m_a = sw; m_st = 2'd2; end
            2'd2: begin m_b = sw; m_cin = sw_cin; m_st = 2'd3; end
            default: m_st = 2'd0;
        endcase
        push_model();
    endtask

    task automatic model_back();
        if (m_st != 2'd0) begin
            m_st = m_st - 2'd1;
            push_model();
        end
    endtask

    task automatic press(input logic n, input logic bk, input string tag);
        @(negedge clk);
        btn_next = n;
        btn_back = bk;
        repeat (D + 4) @(negedge clk);
        btn_next = 1'b0;
        btn_back = 1'b0;
        repeat (D + 4) @(negedge clk);
        check_eq({tag, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; sw = 4'h0; sw_cin = 1'b0; btn_next = 1'b0; btn_back = 1'b0;
        m_st = 2'd0; m_mode = 4'h0; m_a = 4'h0; m_b = 4'h0; m_cin = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", obs(), 16'h0);
        rst_n  = 1'b1;
        mon_en = 1;

        // Clean press: state must change exactly at edge D+3 (pulse after edge D+2).
        sw = 4'h2;
        model_next();
        @(negedge clk);
        btn_next = 1'b1;
        repeat (D + 2) @(posedge clk);
        #1 check_eq("pre_pulse_edge", entry_state, 2'd0);
        @(posedge clk);
        #1 check_eq("post_pulse_edge", entry_state, 2'd1);
        repeat (100) @(negedge clk);
        btn_next = 1'b0;
        repeat (D + 4) @(negedge clk);
        check_eq("hold_drain", exp_q.size(), 0);

        // Bounce 1,0,1,0 then stable high: one acceptance.
        sw = 4'h5;
        model_next();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn_next = (i % 2 == 0);
        end
        press(1'b1, 1'b0, "bounce");

        // Glitch shorter than the debounce interval.
        @(negedge clk);
        btn_next = 1'b1;
        repeat (D - 1) @(negedge clk);
        btn_next = 1'b0;
        repeat (D + 6) @(negedge clk);
        check_eq("glitch_state", entry_state, 2'd2);

        sw = 4'h9; sw_cin = 1'b1;
        model_next();
        press(1'b1, 1'b0, "enter_b");
        check_eq("entry_final", obs(), pk(2'd3, 1'b1, 4'h2, 4'h5, 4'h9));

        sw = 4'hF; sw_cin = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("sw_ignored_run", obs(), pk(2'd3, 1'b1, 4'h2, 4'h5, 4'h9));

        model_next();
        press(1'b1, 1'b0, "run_to_op");
        check_eq("run_to_opcode", obs(), pk(2'd0, 1'b1, 4'h2, 4'h5, 4'h9));

        model_back();
        press(1'b0, 1'b1, "back_in_op");
        check_eq("back_ignored", entry_state, 2'd0);

        // Back from B, new A, then B.
        sw = 4'h2; model_next(); press(1'b1, 1'b0, "op2");
        sw = 4'h5; model_next(); press(1'b1, 1'b0, "a5");
        model_back(); press(1'b0, 1'b1, "b_back");
        sw = 4'h7; model_next(); press(1'b1, 1'b0, "a7");
        sw = 4'hC; model_next(); press(1'b1, 1'b0, "bc");
        check_eq("reentry", obs(), pk(2'd3, 1'b0, 4'h2, 4'h7, 4'hC));

        model_back(); press(1'b0, 1'b1, "run_back");
        model_back(); press(1'b0, 1'b1, "b_back2");
        sw = 4'h6; model_next(); press(1'b1, 1'b1, "both");
        check_eq("next_beats_back", obs(), pk(2'd2, 1'b0, 4'h2, 4'h6, 4'hC));

        sw = 4'h1; model_next(); press(1'b1, 1'b0, "to_run");

        // Synchronous reset from S_RUN.
        m_st = 2'd0; m_mode = 4'h0; m_a = 4'h0; m_b = 4'h0; m_cin = 1'b0;
        push_model();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 check_eq("rst_from_run", obs(), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Press aborted by reset: released during reset, nothing accepted.
        @(negedge clk);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        rst_n    = 1'b0;
        btn_next = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("rst_discard", obs(), 16'h0);

        // Held through reset release: exactly one acceptance afterwards.
        sw = 4'h4;
        model_next();
        @(negedge clk);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (D + 20) @(negedge clk);
        btn_next = 1'b0;
        repeat (D + 4) @(negedge clk);
        check_eq("held_rst_drain", exp_q.size(), 0);
        check_eq("held_rst_state", obs(), pk(2'd1, 1'b0, 4'h4, 4'h0, 4'h0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_entry_ctrl.md
ALU_ENTRY_CTRL -- requirements
Module: alu_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16 (board build: 1_000_000), is the number of consecutive stable synchronized cycles required to accept a button level change.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 sw  input  4  raw slide switches; value latched into the field currently being entered.
REQ-005 sw_cin  input  1  raw carry-in switch, latched together with operand B.
REQ-006 btn_next  input  1  raw, bouncy pushbutton; accepts the current field and advances.
REQ-007 btn_back  input  1  raw, bouncy pushbutton; returns to the previous field without latching.
REQ-008 mode_d  output  4  latched opcode presented to the opcode decoder.
REQ-009 a  output  4  latched operand A.
REQ-010 b  output  4  latched operand B.
REQ-011 c_in  output  1  latched carry-in.
REQ-012 entry_state  output  2  current FSM state encoding, for display/LED status.
REQ-013 operands_valid  output  1  high only while all fields are latched and held for the ALU.

Function
REQ-014 Each raw button shall pass through a 2-flop synchronizer before any other logic.
REQ-015 Debouncer: per button, a counter shall increment each cycle the synchronized value differs from the debounced level, clear to 0 whenever they match, and the debounced level shall take the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES (counter then clears).
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no level change and no pulse.
REQ-017 Press pulse: high for exactly one cycle on each debounced 0->1 transition; no pulse on release.
REQ-018 For a clean press, the press pulse shall be high in the cycle following rising edge number DEBOUNCE_CYCLES+2, counting the first edge that samples the raw input high as edge 1.
REQ-019 FSM states: S_OPCODE=0, S_A=1, S_B=2, S_RUN=3; entry_state equals the state encoding.
REQ-020 S_OPCODE + next pulse: mode_d<=sw, go to S_A.
REQ-021 S_A + next pulse: a<=sw, go to S_B.
REQ-022 S_B + next pulse: b<=sw, c_in<=synchronized sw_cin, go to S_RUN.
REQ-023 S_RUN + next pulse: go to S_OPCODE; mode_d, a, b, c_in retain their values.
REQ-024 Back pulse: S_A->S_OPCODE, S_B->S_A, S_RUN->S_B; in S_OPCODE it is ignored; no register is written.
REQ-025 Next and back pulses in the same cycle: next takes priority; back is discarded.
REQ-026 operands_valid shall be a registered output, high exactly in cycles where the state is S_RUN.
REQ-027 Latched fields shall change only on the next-pulse cycles named in REQ-020..022; switch changes at any other time shall have no effect on outputs.

Reset
REQ-028 With rst_n low at a rising edge: state<=S_OPCODE, mode_d/a/b/c_in<=0, operands_valid<=0, synchronizer flops, debounced levels and counters<=0.
REQ-029 Reset mid-press shall discard the press; a button held through reset release shall produce one pulse after a full debounce interval.

Structure
REQ-030 State encodings and the DEBOUNCE_CYCLES default shall live in a shared package alongside the existing ALU opcode constants.
REQ-031 Synchronizer, debouncer and pulse generation shall be one sub-module, btn_debounce, instantiated once per button.

Verification
REQ-032 DEBOUNCE_CYCLES=4; clean btn_next press -> single pulse after edge 6 exactly per REQ-018; hold 100 cycles -> no further pulse.
REQ-033 Bounce btn_next 1,0,1,0 on alternating cycles then stable 1 -> exactly one pulse; 3-cycle glitch -> no pulse.
REQ-034 Entry sequence sw=0x2, 0x5, 0x9 with sw_cin=1 and three next presses -> mode_d=2, a=5, b=9, c_in=1, operands_valid=1, entry_state=3.
REQ-035 In S_B press back, change sw to 0x7, press next twice -> a=0x7, b=new sw, opcode unchanged; simultaneous next+back in S_A -> advances to S_B.
REQ-036 rst_n low in S_RUN -> next cycle all outputs 0, entry_state=0; rst_n low during a debounce interval -> no pulse.
